johnson_decoder: RTL

- Receive end of the 4-stage Johnson count interface: samples a Johnson-coded word each valid cycle and decodes it to a binary index 0..2N-1.
- Checks that successive codes form a legal forward Johnson sequence; runs a lock state machine and keeps a saturating error count.
- Sits downstream of any Johnson counter, e.g. across a board or clock-domain boundary after synchronisers, so the sequence can be monitored.

---
 rtl/johnson_pkg.sv | 47 ++++
 rtl/johnson_code_decode.sv | 26 ++
 rtl/johnson_decoder.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/johnson_pkg.sv
// rtl/johnson_pkg.sv - shared types and Johnson code helpers
// Purpose: lock-state enum, index-width helper, and width-generic legality
//          and decode functions used by the decoder (and by any future
//          Johnson encoder checker).
// Ports:   none (package).
package johnson_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    LOCKING = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  // Widest code the helpers accept; narrower codes are zero-extended.
  localparam int MAX_STAGES = 16;

  // Bits needed to hold an index in 0..2*stages-1.
  function automatic int idx_w(input int stages);
    return $clog2(2 * stages);
  endfunction

  // A Johnson word has at most one boundary between its run of ones and its
  // run of zeros, so at most one adjacent bit pair may differ.
  function automatic logic jc_legal(input logic [MAX_STAGES-1:0] code,
                                    input int stages);
    int edges;
    edges = 0;
    for (int i = 0; i < MAX_STAGES - 1; i++) begin
      if (i < stages - 1 && code[i] != code[i+1]) edges++;
    end
    return (edges <= 1);
  endfunction

  // Filling phase (msb clear) counts ones upward; draining phase (msb set)
  // counts down from 2N as ones leave from the low end.
  function automatic int jc_index(input logic [MAX_STAGES-1:0] code,
                                  input int stages);
    int p;
    p = 0;
    for (int i = 0; i < MAX_STAGES; i++) begin
      if (i < stages && code[i]) p++;
    end
    if (code[stages-1]) return 2 * stages - p;
    return p;
  endfunction

endpackage

// File: rtl/johnson_code_decode.sv
// rtl/johnson_code_decode.sv - combinational Johnson word to index decoder
// Purpose: flags whether a word is a legal Johnson code and decodes it to
//          its sequence position.
// Ports:   code  - Johnson-coded input word (STAGES bits)
//          legal - word is a legal Johnson code
//          idx   - decoded index 0..2*STAGES-1 (meaningful only when legal)
module johnson_code_decode
  import johnson_pkg::*;
#(
  parameter  int STAGES = 4,
  localparam int IDX_W  = idx_w(STAGES)
) (
  input  logic [STAGES-1:0] code,
  output logic              legal,
  output logic [IDX_W-1:0]  idx
);

  logic [MAX_STAGES-1:0] code_ext;

  always_comb begin
    code_ext = MAX_STAGES'(code);
    legal    = jc_legal(code_ext, STAGES);
    idx      = IDX_W'(jc_index(code_ext, STAGES));
  end

endmodule

// File: rtl/johnson_decoder.sv
// rtl/johnson_decoder.sv - Johnson sequence decoder and lock monitor
// Purpose: samples a Johnson word each valid cycle, registers its decoded
//          index, tracks forward-sequence lock and counts errors seen while
//          locked.
// Ports:   clk, rst (async active-low)
//          in_valid, code      - sample strobe and Johnson word
//          err_clr             - synchronous clear of err_cnt
//          idx, idx_valid      - registered index and legal-sample pulse
//          illegal, seq_err    - illegal-word pulse, locked-error pulse
//          locked, err_cnt     - lock status and saturating error count
module johnson_decoder
  import johnson_pkg::*;
#(
  parameter  int STAGES   = 4,
  parameter  int LOCK_CNT = 2,
  parameter  int ERR_W    = 8,
  localparam int IDX_W    = idx_w(STAGES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [STAGES-1:0] code,
  input  logic              err_clr,
  output logic [IDX_W-1:0]  idx,
  output logic              idx_valid,
  output logic              illegal,
  output logic              seq_err,
  output logic              locked,
  output logic [ERR_W-1:0]  err_cnt
);

  localparam int             RUN_W    = 4;
  localparam logic [IDX_W-1:0] TOP_IDX  = IDX_W'(2 * STAGES - 1);
  localparam logic [RUN_W-1:0] RUN_DONE = RUN_W'(LOCK_CNT);

  logic             dec_legal;
  logic [IDX_W-1:0] dec_idx;

  johnson_code_decode #(.STAGES(STAGES)) u_decode (
    .code  (code),
    .legal (dec_legal),
    .idx   (dec_idx)
  );

  state_e           state_q,     state_d;
  logic [IDX_W-1:0] last_q,      last_d;
  logic [RUN_W-1:0] run_q,       run_d;
  logic [IDX_W-1:0] idx_q,       idx_d;
  logic             idx_valid_q, idx_valid_d;
  logic             illegal_q,   illegal_d;
  logic             seq_err_q,   seq_err_d;
  logic             locked_q,    locked_d;
  logic [ERR_W-1:0] err_cnt_q,   err_cnt_d;

  logic [IDX_W-1:0] expected;
  logic [RUN_W-1:0] run_inc;
  logic             match;
  logic             err_inc;

  always_comb begin
    // Explicit wrap so non-power-of-two sequence lengths also close the loop.
    expected    = (last_q == TOP_IDX) ? '0 : last_q + 1'b1;
    run_inc     = run_q + 1'b1;
    match       = dec_legal && (dec_idx == expected);
    err_inc     = 1'b0;

    state_d     = state_q;
    last_d      = last_q;
    run_d       = run_q;
    idx_d       = idx_q;
    idx_valid_d = 1'b0;
    illegal_d   = 1'b0;
    seq_err_d   = 1'b0;

    if (in_valid) begin
      idx_valid_d = dec_legal;
      illegal_d   = !dec_legal;
      if (dec_legal) begin
        last_d = dec_idx;
        idx_d  = dec_idx;
      end

      unique case (state_q)
        SEARCH: begin
          if (dec_legal) begin
            state_d = LOCKING;
            run_d   = '0;
          end
        end
        LOCKING: begin
          if (!dec_legal) begin
            state_d = SEARCH;
          end else if (match) begin
            run_d = run_inc;
            if (run_inc == RUN_DONE) state_d = LOCKED;
          end else begin
            run_d = '0;
          end
        end
        LOCKED: begin
          if (!match) begin
            seq_err_d = 1'b1;
            err_inc   = 1'b1;
            run_d     = '0;
            state_d   = dec_legal ? LOCKING : SEARCH;
          end
        end
        default: state_d = SEARCH;
      endcase
    end

    locked_d = (state_d == LOCKED);

    // A clear that coincides with an error still records that error.
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = err_inc ? ERR_W'(1) : '0;
    end else if (err_inc && !(&err_cnt_q)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= SEARCH;
      last_q      <= '0;
      run_q       <= '0;
      idx_q       <= '0;
      idx_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      seq_err_q   <= 1'b0;
      locked_q    <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      run_q       <= run_d;
      idx_q       <= idx_d;
      idx_valid_q <= idx_valid_d;
      illegal_q   <= illegal_d;
      seq_err_q   <= seq_err_d;
      locked_q    <= locked_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign idx       = idx_q;
  assign idx_valid = idx_valid_q;
  assign illegal   = illegal_q;
  assign seq_err   = seq_err_q;
  assign locked    = locked_q;
  assign err_cnt   = err_cnt_q;

endmodule
